calc_fsm_p: RTL and testbench



---
 rtl/calc_pkg.sv | 49 ++++
 rtl/calc_fsm_p_if.sv | 29 ++
 rtl/calc_mul_seq.sv | 78 +++++++
 rtl/calc_fsm_p.sv | 212 +++++++++++++++++++++
 tb/tb_calc_fsm_p.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator: key codes, FSM states,
// operator encoding and the digit-count to operand-width helper.
package calc_pkg;

  localparam logic [3:0] KEY_ADD  = 4'd10;
  localparam logic [3:0] KEY_SUB  = 4'd11;
  localparam logic [3:0] KEY_MUL  = 4'd12;
  localparam logic [3:0] KEY_EQ   = 4'd13;
  localparam logic [3:0] KEY_CLR  = 4'd14;
  localparam logic [3:0] KEY_NONE = 4'd15;

  typedef enum logic [2:0] {
    S_OPA    = 3'd0,
    S_OPB    = 3'd1,
    S_CALC   = 3'd2,
    S_RESULT = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  function automatic int pow10(input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  // Smallest width able to hold every DIGITS-digit decimal operand.
  function automatic int opw_for(input int digits);
    int w;
    w = 0;
    while ((1 << w) < pow10(digits)) w = w + 1;
    return w;
  endfunction

  function automatic op_e key_to_op(input logic [3:0] code);
    case (code)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_fsm_p_if.sv
// Key-event input and display-bundle output of the calculator controller.
// The keypad side uses the master modport, the calculator the slave modport.
interface calc_fsm_p_if
  import calc_pkg::*;
#(parameter int DIGITS = 3);

  localparam int OPW  = opw_for(DIGITS);
  localparam int RESW = 2 * OPW;

  logic            key_valid;
  logic [3:0]      key_code;
  logic [RESW-1:0] disp_value;
  logic            disp_neg;
  logic [1:0]      disp_src;
  logic            busy;
  logic            err;
  logic [2:0]      state_o;

  modport master (
    output key_valid, key_code,
    input  disp_value, disp_neg, disp_src, busy, err, state_o
  );

  modport slave (
    input  key_valid, key_code,
    output disp_value, disp_neg, disp_src, busy, err, state_o
  );

endinterface

// File: rtl/calc_mul_seq.sv
// Shift-add multiplier: the first partial product is folded into the start cycle
// so the product is ready and done pulses exactly OPW cycles after start.
module calc_mul_seq #(
  parameter int OPW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              start,
  input  logic [OPW-1:0]    a,
  input  logic [OPW-1:0]    b,
  output logic              done,
  output logic [2*OPW-1:0]  product
);

  localparam int RESW = 2 * OPW;
  localparam int CW   = $clog2(OPW + 1);

  logic [RESW-1:0] mcand_q, mcand_d;
  logic [OPW-1:0]  mplier_q, mplier_d;
  logic [RESW-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  logic            done_q, done_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (abort) begin
      mcand_d  = '0;
      mplier_d = '0;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b0;
    end else if (start) begin
      acc_d    = b[0] ? RESW'(a) : '0;
      mcand_d  = RESW'(a) << 1;
      mplier_d = b >> 1;
      cnt_d    = CW'(1);
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(OPW - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/calc_fsm_p.sv
// Keypad calculator controller: decimal operand entry, add/sub/multiply with
// result chaining and an error state, driving a registered display bundle.
module calc_fsm_p
  import calc_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  calc_fsm_p_if.slave  bus
);

  localparam int OPW  = opw_for(DIGITS);
  localparam int RESW = 2 * OPW;
  localparam logic [RESW-1:0] MAX_OPERAND = RESW'(pow10(DIGITS) - 1);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [OPW-1:0]  opa_q, opa_d;
  logic [OPW-1:0]  opb_q, opb_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [RESW-1:0] result_q, result_d;
  logic            neg_q, neg_d;
  logic [RESW-1:0] disp_value_q, disp_value_d;
  logic            disp_neg_q, disp_neg_d;
  logic [1:0]      disp_src_q, disp_src_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            key_ok, is_digit, is_op, is_eq, is_clr;
  logic            mul_start, mul_done;
  logic [RESW-1:0] mul_product;
  logic [OPW-1:0]  digit_val;

  assign key_ok    = bus.key_valid && (bus.key_code != KEY_NONE);
  assign is_digit  = key_ok && (bus.key_code <= 4'd9);
  assign is_op     = key_ok && ((bus.key_code == KEY_ADD) || (bus.key_code == KEY_SUB) ||
                                (bus.key_code == KEY_MUL));
  assign is_eq     = key_ok && (bus.key_code == KEY_EQ);
  assign is_clr    = key_ok && (bus.key_code == KEY_CLR);
  assign digit_val = OPW'(bus.key_code);

  calc_mul_seq #(.OPW(OPW)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .abort   (is_clr),
    .start   (mul_start),
    .a       (opa_q),
    .b       (opb_q),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    neg_d     = neg_q;
    mul_start = 1'b0;

    if (is_clr) begin
      state_d  = S_OPA;
      op_d     = OP_ADD;
      opa_d    = '0;
      opb_d    = '0;
      cnt_d    = '0;
      result_d = '0;
      neg_d    = 1'b0;
    end else begin
      case (state_q)
        S_OPA: begin
          if (is_digit) begin
            if (cnt_q < 3'(DIGITS)) begin
              opa_d = opa_q * OPW'(10) + digit_val;
              cnt_d = cnt_q + 3'd1;
            end
          end else if (is_op) begin
            op_d    = key_to_op(bus.key_code);
            opb_d   = '0;
            cnt_d   = '0;
            state_d = S_OPB;
          end
        end
        S_OPB: begin
          if (is_digit) begin
            if (cnt_q < 3'(DIGITS)) begin
              opb_d = opb_q * OPW'(10) + digit_val;
              cnt_d = cnt_q + 3'd1;
            end
          end else if (is_op) begin
            if (cnt_q == 3'd0) op_d = key_to_op(bus.key_code);
          end else if (is_eq && (cnt_q != 3'd0)) begin
            state_d   = S_CALC;
            mul_start = (op_q == OP_MUL);
          end
        end
        S_CALC: begin
          case (op_q)
            OP_ADD: begin
              result_d = RESW'(opa_q) + RESW'(opb_q);
              neg_d    = 1'b0;
              state_d  = S_RESULT;
            end
            OP_SUB: begin
              if (opa_q < opb_q) begin
                result_d = RESW'(opb_q - opa_q);
                neg_d    = 1'b1;
              end else begin
                result_d = RESW'(opa_q - opb_q);
                neg_d    = 1'b0;
              end
              state_d = S_RESULT;
            end
            OP_MUL: begin
              if (mul_done) begin
                result_d = mul_product;
                neg_d    = 1'b0;
                state_d  = S_RESULT;
              end
            end
            default: state_d = S_ERR;
          endcase
        end
        S_RESULT: begin
          if (is_digit) begin
            opa_d   = digit_val;
            cnt_d   = 3'd1;
            state_d = S_OPA;
          end else if (is_op) begin
            // Chaining only works if the result is itself a legal operand.
            if (!neg_q && (result_q <= MAX_OPERAND)) begin
              opa_d   = OPW'(result_q);
              op_d    = key_to_op(bus.key_code);
              opb_d   = '0;
              cnt_d   = '0;
              state_d = S_OPB;
            end else begin
              state_d = S_ERR;
            end
          end
        end
        S_ERR: state_d = S_ERR;
        default: state_d = S_OPA;
      endcase
    end

    disp_neg_d = 1'b0;
    case (state_d)
      S_OPA: begin
        disp_value_d = RESW'(opa_d);
        disp_src_d   = 2'd0;
      end
      S_OPB, S_CALC: begin
        if (cnt_d == 3'd0) begin
          disp_value_d = RESW'(opa_d);
          disp_src_d   = 2'd0;
        end else begin
          disp_value_d = RESW'(opb_d);
          disp_src_d   = 2'd1;
        end
      end
      default: begin
        disp_value_d = result_d;
        disp_src_d   = 2'd2;
        disp_neg_d   = neg_d;
      end
    endcase
    busy_d = (state_d == S_CALC) && (op_d == OP_MUL);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_OPA;
      op_q         <= OP_ADD;
      opa_q        <= '0;
      opb_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      neg_q        <= 1'b0;
      disp_value_q <= '0;
      disp_neg_q   <= 1'b0;
      disp_src_q   <= 2'd0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      neg_q        <= neg_d;
      disp_value_q <= disp_value_d;
      disp_neg_q   <= disp_neg_d;
      disp_src_q   <= disp_src_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign bus.disp_value = disp_value_q;
  assign bus.disp_neg   = disp_neg_q;
  assign bus.disp_src   = disp_src_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_calc_fsm_p.sv
// Self-checking bench for calc_fsm_p: directed keypad sequences with literal
// expectations, then random key traffic against a behavioural calculator model.
module tb_calc_fsm_p;

  localparam int DIGITS = 3;
  localparam int OPW    = $clog2(10 ** DIGITS);
  localparam int MAXV   = 10 ** DIGITS - 1;

  localparam int M_OPA = 0, M_OPB = 1, M_CALC = 2, M_RES = 3, M_ERR = 4;

  logic clk;
  logic reset;

  calc_fsm_p_if #(.DIGITS(DIGITS)) bus ();

  calc_fsm_p #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit model_on = 1'b0;

  // Calculator as a user sees it: two operands, a pending operator, a result
  // and a countdown of how many cycles the calculation still takes.
  int m_state, m_opa, m_opb, m_cnt, m_op, m_res, m_neg, m_remain;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit kv, input int kc);
    bit key;
    key = kv && (kc != 15);
    if (rst || (kv && kc == 14)) begin
      m_state = M_OPA; m_opa = 0; m_opb = 0; m_cnt = 0;
      m_op = 10; m_res = 0; m_neg = 0; m_remain = 0;
    end else begin
      case (m_state)
        M_OPA: begin
          if (key && kc < 10) begin
            if (m_cnt < DIGITS) begin m_opa = m_opa * 10 + kc; m_cnt++; end
          end else if (key && kc >= 10 && kc <= 12) begin
            m_op = kc; m_opb = 0; m_cnt = 0; m_state = M_OPB;
          end
        end
        M_OPB: begin
          if (key && kc < 10) begin
            if (m_cnt < DIGITS) begin m_opb = m_opb * 10 + kc; m_cnt++; end
          end else if (key && kc >= 10 && kc <= 12) begin
            if (m_cnt == 0) m_op = kc;
          end else if (key && kc == 13 && m_cnt > 0) begin
            m_state  = M_CALC;
            m_remain = (m_op == 12) ? OPW : 1;
          end
        end
        M_CALC: begin
          m_remain--;
          if (m_remain == 0) begin
            if (m_op == 10) begin m_res = m_opa + m_opb; m_neg = 0; end
            else if (m_op == 11) begin
              m_neg = (m_opa < m_opb) ? 1 : 0;
              m_res = m_neg ? (m_opb - m_opa) : (m_opa - m_opb);
            end else begin m_res = m_opa * m_opb; m_neg = 0; end
            m_state = M_RES;
          end
        end
        M_RES: begin
          if (key && kc < 10) begin
            m_opa = kc; m_cnt = 1; m_state = M_OPA;
          end else if (key && kc >= 10 && kc <= 12) begin
            if (m_neg == 0 && m_res <= MAXV) begin
              m_opa = m_res; m_op = kc; m_opb = 0; m_cnt = 0; m_state = M_OPB;
            end else begin
              m_state = M_ERR;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    int e_disp, e_src, e_neg;
    forever begin
      @(posedge clk);
      #1;
      model_step(reset, bus.key_valid, int'(bus.key_code));
      if (reset) model_on = 1'b1;
      if (model_on) begin
        if (m_state == M_OPA) begin
          e_disp = m_opa; e_src = 0; e_neg = 0;
        end else if (m_state == M_OPB || m_state == M_CALC) begin
          e_disp = (m_cnt == 0) ? m_opa : m_opb;
          e_src  = (m_cnt == 0) ? 0 : 1;
          e_neg  = 0;
        end else begin
          e_disp = m_res; e_src = 2; e_neg = m_neg;
        end
        check_output("model_state", 32'(bus.state_o), m_state);
        check_output("model_disp_value", 32'(bus.disp_value), e_disp);
        check_output("model_disp_src", 32'(bus.disp_src), e_src);
        check_output("model_disp_neg", 32'(bus.disp_neg), e_neg);
        check_output("model_busy", 32'(bus.busy), (m_state == M_CALC && m_op == 12) ? 1 : 0);
        check_output("model_err", 32'(bus.err), (m_state == M_ERR) ? 1 : 0);
      end
    end
  end

  task automatic apply_stimulus(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic type_keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      logic [3:0] code;
      c = s[i];
      case (c)
        "+":     code = 4'd10;
        "-":     code = 4'd11;
        "*":     code = 4'd12;
        "=":     code = 4'd13;
        "C":     code = 4'd14;
        default: code = 4'(c - 8'd48);
      endcase
      apply_stimulus(code);
    end
  endtask

  task automatic wait_state(input string name, input int target, input int max_cyc);
    int n;
    n = 0;
    while (bus.state_o !== 3'(target) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(bus.state_o), target);
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_state"}, 32'(bus.state_o), 0);
    check_output({tag, "_busy"}, 32'(bus.busy), 0);
    check_output({tag, "_disp"}, 32'(bus.disp_value), 0);
    check_output({tag, "_src"}, 32'(bus.disp_src), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy_cycles;
    int r;
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check_output("reset_err", 32'(bus.err), 0);
    reset = 1'b0;

    $display("[TB] add with fourth digit ignored");
    type_keys("1234+45=");
    check_output("add_calc_state", 32'(bus.state_o), 2);
    @(negedge clk);
    check_output("add_state", 32'(bus.state_o), 3);
    check_output("add_value", 32'(bus.disp_value), 168);
    check_output("add_neg", 32'(bus.disp_neg), 0);
    check_output("add_src", 32'(bus.disp_src), 2);
    check_output("model_pin_168", m_res, 168);

    $display("[TB] subtract and operator replace");
    type_keys("5-9=");
    @(negedge clk);
    check_output("sub_value", 32'(bus.disp_value), 4);
    check_output("sub_neg", 32'(bus.disp_neg), 1);
    type_keys("7+-3=");
    @(negedge clk);
    check_output("replace_value", 32'(bus.disp_value), 4);
    check_output("replace_neg", 32'(bus.disp_neg), 0);

    $display("[TB] multiply 999*999");
    type_keys("999*999=");
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy !== 1'b1) break;
      busy_cycles++;
      bus.key_valid = (i < 3);
      bus.key_code  = 4'd5;
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    check_output("mul_busy_cycles", busy_cycles, 10);
    check_output("mul_state", 32'(bus.state_o), 3);
    check_output("mul_value", 32'(bus.disp_value), 998001);
    check_output("mul_neg", 32'(bus.disp_neg), 0);
    check_output("model_pin_998001", m_res, 998001);

    $display("[TB] chaining and error");
    type_keys("C12+3=");
    @(negedge clk);
    check_output("chain_15", 32'(bus.disp_value), 15);
    type_keys("*2=");
    wait_state("chain_wait", 3, 20);
    check_output("chain_30", 32'(bus.disp_value), 30);
    type_keys("C999*2=");
    wait_state("big_wait", 3, 20);
    check_output("big_1998", 32'(bus.disp_value), 1998);
    type_keys("+");
    check_output("err_flag", 32'(bus.err), 1);
    check_output("err_state", 32'(bus.state_o), 4);
    type_keys("5=");
    check_output("err_hold_value", 32'(bus.disp_value), 1998);
    check_output("err_hold_src", 32'(bus.disp_src), 2);
    type_keys("C");
    check_idle("err_clear");
    check_output("err_clear_err", 32'(bus.err), 0);

    $display("[TB] abort multiply with clear and reset");
    type_keys("999*999=");
    repeat (4) @(negedge clk);
    check_output("abort_busy_before", 32'(bus.busy), 1);
    type_keys("C");
    check_idle("clr_abort");
    repeat (15) @(negedge clk);
    check_idle("clr_abort_later");
    type_keys("999*999=");
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("rst_abort");
    repeat (15) @(negedge clk);
    check_idle("rst_abort_later");

    $display("[TB] random key traffic");
    for (int i = 0; i < 1500; i++) begin
      reset         = ($urandom_range(0, 299) == 0);
      bus.key_valid = ($urandom_range(0, 99) < 60);
      r = $urandom_range(0, 99);
      if (r < 55)      bus.key_code = 4'($urandom_range(0, 9));
      else if (r < 70) bus.key_code = 4'($urandom_range(10, 12));
      else if (r < 87) bus.key_code = 4'd13;
      else if (r < 90) bus.key_code = 4'd14;
      else             bus.key_code = 4'd15;
      @(negedge clk);
    end
    reset         = 1'b0;
    bus.key_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
